uart_rx_fifo: RTL

Parametrised receive path for the next-generation UART: a 2-flop input synchroniser, an oversampled start/data/parity/stop receiver supporting 5–8 bit words, and a receive FIFO of configurable depth with per-entry error flags, trigger-level and character-timeout interrupts. It replaces the single-holding-register receiver inside `uart_16550`. The register file drives its configuration inputs and consumes its FIFO read port.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_sync_fifo.sv | 61 ++++++
 rtl/uart_rx_fifo.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BRK_WAIT
    } rx_state_e;

    typedef struct packed {
        logic       brk;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

    localparam int UART_TIMEOUT_BITS = 40;
    localparam int RX_ENTRY_W        = $bits(rx_entry_t);

    // Unused upper data bits are zero, so they do not disturb the reduction.
    function automatic logic rx_parity_err(input logic pbit, input logic [7:0] data,
                                           input logic even);
        return pbit ^ (^data) ^ ~even;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous show-ahead FIFO with registered head and occupancy count
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_ptr_nx;
    logic             rd_ok;
    logic             wr_ok;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count     = CNT_W'(wr_ptr - rd_ptr);
    assign rd_ok     = rd_en & ~empty;
    // A pop frees the slot being written, so a full FIFO can still accept.
    assign wr_ok     = wr_en & (~full | rd_ok);
    assign rd_ptr_nx = rd_ptr + {{AW{1'b0}}, rd_ok};

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Head register: bypass the write when the new entry becomes the head,
    // otherwise fetch the next stored entry; hold when the FIFO drains.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_nx;
            if (wr_ok && (rd_ptr_nx == wr_ptr)) begin
                rd_data <= wr_data;
            end else if (rd_ok && (rd_ptr_nx != wr_ptr)) begin
                rd_data <= mem[rd_ptr_nx[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampled UART receiver feeding a flagged receive FIFO with interrupts
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] divisor,
    input  logic [1:0]       word_len,
    input  logic             parity_en,
    input  logic             parity_even,
    input  logic             rx,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             rd_perr,
    output logic             rd_ferr,
    output logic             rd_brk,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    input  logic [CNT_W-1:0] trig,
    output logic             irq_trig,
    output logic             irq_timeout,
    output logic             overrun,
    input  logic             clr_overrun
);

    localparam int              OS_W     = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam int              TO_TICKS = UART_TIMEOUT_BITS * OVERSAMPLE;
    localparam int              TO_W     = $clog2(TO_TICKS + 1);

    logic             rx_meta, rx_sync, rx_prev;
    logic             start_edge;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    rx_state_e        state, state_nx;
    logic             restart, samp;
    logic [OS_W-1:0]  os_cnt;
    logic [2:0]       bit_idx;
    logic             bit_last;
    logic [7:0]       data_q;
    logic             any_one;
    logic             perr_q;
    logic             brk_now;
    logic [1:0]       wl_l;
    logic             par_en_l, par_even_l;
    logic             push_q;
    rx_entry_t        push_entry;
    rx_entry_t        head;
    logic [RX_ENTRY_W-1:0] head_bits;
    logic             fifo_full, fifo_pop, drop;
    logic [CNT_W-1:0] trig_eff;
    logic [TO_W-1:0]  to_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = rx_prev & ~rx_sync;
    assign tick       = (divisor != '0) && (div_cnt == '0);

    // Restart on a start edge so sampling phase is relative to the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (divisor != '0) begin
            if (restart || (div_cnt == '0)) begin
                div_cnt <= divisor - 1'b1;
            end else begin
                div_cnt <= div_cnt - 1'b1;
            end
        end
    end

    assign bit_last = (bit_idx == ({1'b0, wl_l} + 3'd4));
    assign brk_now  = ~any_one & ~rx_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            RX_IDLE:     if (restart) state_nx = RX_START;
            RX_START:    if (samp) state_nx = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:     if (samp && bit_last) state_nx = par_en_l ? RX_PARITY : RX_STOP;
            RX_PARITY:   if (samp) state_nx = RX_STOP;
            RX_STOP:     if (samp) state_nx = brk_now ? RX_BRK_WAIT : RX_IDLE;
            RX_BRK_WAIT: if (samp && rx_sync) state_nx = RX_IDLE;
            default:     state_nx = RX_IDLE;
        endcase
    end

    always_comb begin
        restart = 1'b0;
        samp    = 1'b0;
        unique case (state)
            RX_IDLE:                    restart = start_edge;
            RX_START:                   samp = tick && (os_cnt == OS_HALF);
            RX_DATA, RX_PARITY, RX_STOP: samp = tick && (os_cnt == OS_LAST);
            RX_BRK_WAIT:                samp = tick;
            default:                    samp = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            os_cnt     <= '0;
            bit_idx    <= '0;
            data_q     <= '0;
            any_one    <= 1'b0;
            perr_q     <= 1'b0;
            wl_l       <= '0;
            par_en_l   <= 1'b0;
            par_even_l <= 1'b0;
            push_q     <= 1'b0;
            push_entry <= '0;
        end else begin
            push_q <= 1'b0;
            if (restart) begin
                os_cnt     <= '0;
                bit_idx    <= '0;
                data_q     <= '0;
                any_one    <= 1'b0;
                perr_q     <= 1'b0;
                wl_l       <= word_len;
                par_en_l   <= parity_en;
                par_even_l <= parity_even;
            end else if (tick) begin
                os_cnt <= samp ? '0 : os_cnt + 1'b1;
                if (samp) begin
                    case (state)
                        RX_DATA: begin
                            data_q[bit_idx] <= rx_sync;
                            any_one         <= any_one | rx_sync;
                            bit_idx         <= bit_idx + 1'b1;
                        end
                        RX_PARITY: begin
                            perr_q  <= rx_parity_err(rx_sync, data_q, par_even_l);
                            any_one <= any_one | rx_sync;
                        end
                        RX_STOP: begin
                            // A break frame has all-zero data, so data_q is already 0x00.
                            push_q          <= 1'b1;
                            push_entry.brk  <= brk_now;
                            push_entry.ferr <= ~rx_sync;
                            push_entry.perr <= perr_q & ~brk_now;
                            push_entry.data <= data_q;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    uart_sync_fifo #(
        .WIDTH (RX_ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_q),
        .wr_data (push_entry),
        .rd_en   (rd_en),
        .rd_data (head_bits),
        .empty   (empty),
        .full    (fifo_full),
        .count   (count)
    );

    assign head     = rx_entry_t'(head_bits);
    assign rd_data  = head.data;
    assign rd_perr  = head.perr;
    assign rd_ferr  = head.ferr;
    assign rd_brk   = head.brk;
    assign fifo_pop = rd_en & ~empty;
    assign drop     = push_q & fifo_full & ~rd_en;
    assign trig_eff = (trig == '0) ? CNT_W'(1) : trig;
    assign irq_trig = (count >= trig_eff);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

    // Counter saturates at the threshold so the interrupt stays until FIFO activity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt      <= '0;
            irq_timeout <= 1'b0;
        end else if (push_q || fifo_pop || empty) begin
            to_cnt      <= '0;
            irq_timeout <= 1'b0;
        end else if (tick && (to_cnt != TO_W'(TO_TICKS))) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TO_W'(TO_TICKS - 1)) begin
                irq_timeout <= 1'b1;
            end
        end
    end

endmodule
